// File: rtl/vedic_mul52_seq_ctrl.sv
// 52x52 unsigned mantissa multiplier controller: one shared 26x26 multiplier is
// time-shared over the LL, LH, HL and HH partial products, which are summed in a 104-bit accumulator.
module vedic_mul52_seq_ctrl #(
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [51:0]   a,
    input  logic [51:0]   b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [103:0]  mul,
    output logic          busy,
    output logic [25:0]   pp_a,
    output logic [25:0]   pp_b,
    input  logic [51:0]   pp_mul
);

    typedef enum logic [2:0] {IDLE, S_LL, S_LH, S_HL, S_HH, DONE} state_t;

    state_t        state_q, state_d;
    logic [51:0]   a_q, a_d, b_q, b_d;
    logic [103:0]  acc_q, acc_d, mul_q, mul_d;
    logic [103:0]  pp_term;
    logic [6:0]    shift;
    logic          accept;
    logic          is_zero;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_zero   = (a == '0) || (b == '0);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign mul       = mul_q;

    // Operand halves for the shared multiplier, decoded from state and the latched operands.
    always_comb begin
        pp_a  = '0;
        pp_b  = '0;
        shift = 7'd0;
        unique case (state_q)
            S_LL: begin pp_a = a_q[25:0];  pp_b = b_q[25:0];  shift = 7'd0;  end
            S_LH: begin pp_a = a_q[25:0];  pp_b = b_q[51:26]; shift = 7'd26; end
            S_HL: begin pp_a = a_q[51:26]; pp_b = b_q[25:0];  shift = 7'd26; end
            S_HH: begin pp_a = a_q[51:26]; pp_b = b_q[51:26]; shift = 7'd52; end
            default: ;
        endcase
        pp_term = {52'd0, pp_mul} << shift;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_LL: begin acc_d = acc_q + pp_term; state_d = S_LH; end
            S_LH: begin acc_d = acc_q + pp_term; state_d = S_HL; end
            S_HL: begin acc_d = acc_q + pp_term; state_d = S_HH; end
            S_HH: begin
                acc_d   = acc_q + pp_term;
                mul_d   = acc_q + pp_term;
                state_d = DONE;
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: ;
        endcase
        // An accept in DONE overrides the return to IDLE and starts the next product directly.
        if (accept) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            if (BYPASS_ZERO && is_zero) begin
                state_d = DONE;
                mul_d   = '0;
            end else begin
                state_d = S_LL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mul_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
        end
    end

    // Operand latches only matter once an accept has loaded them.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

endmodule
